// File: rtl/extreme_scan_if.sv
// ============================================================================
// extreme_scan_if : frame-control and keypoint-stream bundle for extreme_scan_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

interface extreme_scan_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic          start;
   logic          feed_en;
   logic          det_flag;
   logic [7:0]    det_center;
   logic          kp_valid;
   logic          kp_ready;
   logic [XW-1:0] kp_x;
   logic [YW-1:0] kp_y;
   logic [7:0]    kp_val;
   logic          busy;
   logic          done;
   logic [15:0]   kp_count;

   modport master (
      input  start, det_flag, det_center, kp_ready,
      output feed_en, kp_valid, kp_x, kp_y, kp_val, busy, done, kp_count
   );

   modport slave (
      output start, det_flag, det_center, kp_ready,
      input  feed_en, kp_valid, kp_x, kp_y, kp_val, busy, done, kp_count
   );
endinterface

`default_nettype wire

// File: rtl/extreme_scan_ctrl.sv
// ============================================================================
// extreme_scan_ctrl : paces the 3x3x3 DoG extreme detector over a frame and
//                     queues border-masked, contrast-filtered keypoints.
// Revision: 1.0
// ============================================================================
`default_nettype none

module extreme_scan_ctrl #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int XW         = 10,
   parameter int YW         = 9,
   parameter int PIPE_LAT   = 7,
   parameter int THRESH     = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   extreme_scan_if.master bus
);
   localparam int LW = $clog2(PIPE_LAT + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = XW + YW + 8;

   localparam logic [XW-1:0] c_X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_H - 1);
   localparam logic [LW-1:0] c_LAT    = LW'(PIPE_LAT);
   localparam logic [CW-1:0] c_STALL  = CW'(FIFO_DEPTH - 2);
   localparam logic [CW-1:0] c_FULL   = CW'(FIFO_DEPTH);
   localparam logic [7:0]    c_THRESH = 8'(THRESH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   logic          r_busy;
   logic          r_done;
   logic [15:0]   r_kp_count;
   logic [XW-1:0] r_fx, r_rx;
   logic [YW-1:0] r_fy, r_ry;
   logic [LW-1:0] r_lat, r_drain;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_wp, r_rp;
   logic [DW-1:0] r_mem [FIFO_DEPTH];

   logic          w_active, w_feed_en, w_live, w_push, w_pop, w_valid;
   logic [7:0]    w_abs;
   logic [DW-1:0] w_head;

   assign w_active  = (r_state == S_FEED) || (r_state == S_DRAIN);
   // Stall one entry early so a result sampled this cycle always has room.
   assign w_feed_en = w_active && (r_count <= c_STALL);
   assign w_live    = (r_lat == c_LAT);
   assign w_abs     = bus.det_center[7] ? (~bus.det_center + 8'd1) : bus.det_center;
   assign w_push    = w_feed_en && w_live && (r_rx >= XW'(2)) && (r_ry >= YW'(2))
                      && bus.det_flag && (w_abs >= c_THRESH);
   assign w_valid   = (r_count != '0);
   assign w_pop     = w_valid && bus.kp_ready;
   assign w_head    = r_mem[r_rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_kp_count <= '0;
         r_fx       <= '0;
         r_fy       <= '0;
         r_rx       <= '0;
         r_ry       <= '0;
         r_lat      <= '0;
         r_drain    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state    <= S_FEED;
                  r_busy     <= 1'b1;
                  r_kp_count <= '0;
                  r_fx       <= '0;
                  r_fy       <= '0;
                  r_rx       <= '0;
                  r_ry       <= '0;
                  r_lat      <= '0;
                  r_drain    <= '0;
               end
            end
            S_FEED: begin
               if (w_feed_en) begin
                  if (r_fx == c_X_LAST) begin
                     r_fx <= '0;
                     if (r_fy == c_Y_LAST) r_state <= S_DRAIN;
                     else                  r_fy    <= r_fy + YW'(1);
                  end else begin
                     r_fx <= r_fx + XW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (w_feed_en) begin
                  if (r_drain == c_LAT - LW'(1)) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_drain <= r_drain + LW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Result coordinates trail the feed by PIPE_LAT enabled cycles.
         if (w_feed_en) begin
            if (!w_live) begin
               r_lat <= r_lat + LW'(1);
            end else if (r_rx == c_X_LAST) begin
               r_rx <= '0;
               r_ry <= r_ry + YW'(1);
            end else begin
               r_rx <= r_rx + XW'(1);
            end
         end

         if (w_push && (r_kp_count != 16'hFFFF)) r_kp_count <= r_kp_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= {r_rx - XW'(1), r_ry - YW'(1), bus.det_center};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == c_FULL)));

   assign bus.feed_en  = w_feed_en;
   assign bus.kp_valid = w_valid;
   assign bus.kp_x     = w_valid ? w_head[DW-1 -: XW]  : '0;
   assign bus.kp_y     = w_valid ? w_head[YW+7 -: YW]  : '0;
   assign bus.kp_val   = w_valid ? w_head[7:0]         : 8'd0;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.kp_count = r_kp_count;

endmodule

`default_nettype wire

// File: tb/tb_extreme_scan_ctrl.sv
// ============================================================================
// tb_extreme_scan_ctrl : directed self-checking bench for extreme_scan_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_extreme_scan_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   mode   = 0;
   int   en_cnt = 0;
   int   valid_cycles = 0;
   int   qx[$], qy[$], qv[$];

   always #5 clk = ~clk;

   extreme_scan_if #(.XW(3), .YW(3)) bus ();

   extreme_scan_ctrl #(
      .IMG_W(8), .IMG_H(6), .XW(3), .YW(3),
      .PIPE_LAT(7), .THRESH(3), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // {flag, centre} the detector reports for the window whose newest pixel is (rx, ry)
   function automatic logic [8:0] pat(input int m, input int rx, input int ry);
      logic [8:0] p;
      p = 9'd0;
      case (m)
         1: if (rx == 4 && ry == 3) p = {1'b1, 8'd5};
         2: begin
            if (rx == 2 && ry == 2) p = {1'b1, 8'd2};
            if (rx == 3 && ry == 2) p = {1'b1, 8'hFD};
            if (rx == 0 && ry == 3) p = {1'b1, 8'd9};
            if (rx == 5 && ry == 1) p = {1'b1, 8'd9};
            if (rx == 6 && ry == 4) p = {1'b1, 8'h80};
         end
         3: p = {1'b1, 8'(rx * 16 + ry)};
         default: p = 9'd0;
      endcase
      return p;
   endfunction

   // Detector stand-in: frozen on stall cycles, PIPE_LAT enables of latency.
   always @(negedge clk) begin
      logic [8:0] p;
      if (rst || !bus.busy) begin
         en_cnt         = 0;
         bus.det_flag   = 1'b0;
         bus.det_center = 8'd0;
      end else if (bus.feed_en) begin
         p = 9'd0;
         if (en_cnt >= 7) p = pat(mode, (en_cnt - 7) % 8, (en_cnt - 7) / 8);
         bus.det_flag   = p[8];
         bus.det_center = p[7:0];
         en_cnt++;
      end
   end

   always @(negedge clk) begin
      #1;
      if (bus.kp_valid) valid_cycles++;
      if (bus.kp_valid && bus.kp_ready) begin
         qx.push_back(int'(bus.kp_x));
         qy.push_back(int'(bus.kp_y));
         qv.push_back(int'(bus.kp_val));
      end
   end

   task automatic run_frame(input bit poke, output int fe, output int dn, output int cyc, output bit to);
      fe = 0; dn = 0; cyc = -1; to = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         bus.start = poke && (c == 10 || c == 50);
         if (bus.feed_en) fe++;
         if (bus.done) begin
            dn++;
            cyc = c;
            break;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      if (dn == 0) to = 1'b1;
      @(negedge clk);
      if (bus.done) dn++;
      for (int c = 0; c < 200 && bus.kp_valid; c++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.feed_en !== 1'b0) begin errors++; $display("FAIL reset_feed_en: got %b want 0", bus.feed_en); end
      checks++; if (bus.kp_valid !== 1'b0) begin errors++; $display("FAIL reset_kp_valid: got %b want 0", bus.kp_valid); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", bus.busy, bus.done); end
      checks++; if (bus.kp_count !== 16'd0) begin errors++; $display("FAIL reset_kp_count: got %0d want 0", bus.kp_count); end
      checks++; if ({bus.kp_x, bus.kp_y, bus.kp_val} !== 14'd0) begin errors++; $display("FAIL reset_kp_data: got %h want 0", {bus.kp_x, bus.kp_y, bus.kp_val}); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.feed_en !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy %b feed_en %b want 0 0", bus.busy, bus.feed_en); end
   endtask

   task automatic test_empty_frame();
      int fe, dn, cyc, v0; bit to;
      mode = 0; bus.kp_ready = 1'b1; v0 = valid_cycles;
      run_frame(1'b0, fe, dn, cyc, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL empty_timeout: done never seen"); end
      checks++; if (fe !== 55) begin errors++; $display("FAIL empty_feed_cycles: got %0d want 55", fe); end
      checks++; if (dn !== 1) begin errors++; $display("FAIL empty_done_pulses: got %0d want 1", dn); end
      checks++; if (cyc !== 55) begin errors++; $display("FAIL empty_done_cycle: got %0d want 55", cyc); end
      checks++; if (bus.kp_count !== 16'd0) begin errors++; $display("FAIL empty_kp_count: got %0d want 0", bus.kp_count); end
      checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL empty_kp_valid: got %0d valid cycles want 0", valid_cycles - v0); end
   endtask

   task automatic test_single_kp();
      int fe, dn, cyc, base; bit to;
      mode = 1; bus.kp_ready = 1'b1; base = qx.size();
      run_frame(1'b0, fe, dn, cyc, to);
      checks++; if (qx.size() - base !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", qx.size() - base); end
      if (qx.size() > base) begin
         checks++; if (qx[base] !== 3 || qy[base] !== 2) begin errors++; $display("FAIL single_xy: got (%0d,%0d) want (3,2)", qx[base], qy[base]); end
         checks++; if (qv[base] !== 5) begin errors++; $display("FAIL single_val: got %0d want 5", qv[base]); end
      end
      checks++; if (bus.kp_count !== 16'd1) begin errors++; $display("FAIL single_kp_count: got %0d want 1", bus.kp_count); end
   endtask

   task automatic test_threshold_border();
      int fe, dn, cyc, base; bit to;
      mode = 2; bus.kp_ready = 1'b1; base = qx.size();
      run_frame(1'b0, fe, dn, cyc, to);
      checks++; if (qx.size() - base !== 2) begin errors++; $display("FAIL thresh_count: got %0d want 2", qx.size() - base); end
      if (qx.size() - base >= 2) begin
         checks++; if (qx[base] !== 2 || qy[base] !== 1 || qv[base] !== 253) begin errors++; $display("FAIL thresh_neg3: got (%0d,%0d,%0d) want (2,1,253)", qx[base], qy[base], qv[base]); end
         checks++; if (qx[base+1] !== 5 || qy[base+1] !== 3 || qv[base+1] !== 128) begin errors++; $display("FAIL thresh_neg128: got (%0d,%0d,%0d) want (5,3,128)", qx[base+1], qy[base+1], qv[base+1]); end
      end
      checks++; if (bus.kp_count !== 16'd2) begin errors++; $display("FAIL thresh_kp_count: got %0d want 2", bus.kp_count); end
   endtask

   task automatic test_backpressure();
      int base, n; bit seen;
      mode = 3; bus.kp_ready = 1'b0; base = qx.size();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (150) @(negedge clk);
      checks++; if (bus.kp_count !== 16'd7) begin errors++; $display("FAIL bp_stall_count: got %0d want 7", bus.kp_count); end
      checks++; if (bus.feed_en !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL bp_stalled: feed_en %b busy %b want 0 1", bus.feed_en, bus.busy); end
      checks++; if (bus.kp_valid !== 1'b1 || qx.size() !== base) begin errors++; $display("FAIL bp_held: kp_valid %b popped %0d want 1 0", bus.kp_valid, qx.size() - base); end
      bus.kp_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
         if (bus.done) seen = 1'b1;
         @(negedge clk);
      end
      checks++; if (!seen) begin errors++; $display("FAIL bp_timeout: done %b want 1", seen); end
      for (int c = 0; c < 200 && bus.kp_valid; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      n = qx.size() - base;
      checks++; if (n !== 24) begin errors++; $display("FAIL bp_delivered: got %0d want 24", n); end
      for (int i = 0; i < 24 && i < n; i++) begin
         checks++;
         if (qx[base+i] !== i % 6 + 1 || qy[base+i] !== i / 6 + 1 || qv[base+i] !== (i % 6 + 2) * 16 + (i / 6 + 2)) begin
            errors++;
            $display("FAIL bp_order[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, qx[base+i], qy[base+i], qv[base+i],
                     i % 6 + 1, i / 6 + 1, (i % 6 + 2) * 16 + (i / 6 + 2));
         end
      end
      checks++; if (bus.kp_count !== 16'd24) begin errors++; $display("FAIL bp_kp_count: got %0d want 24", bus.kp_count); end
   endtask

   task automatic test_reset_midframe();
      int fe, dn, cyc, base; bit to;
      mode = 3; bus.kp_ready = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (bus.kp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", bus.kp_valid); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.kp_valid !== 1'b0 || bus.feed_en !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy %b kp_valid %b feed_en %b want 0 0 0", bus.busy, bus.kp_valid, bus.feed_en); end
      checks++; if (bus.kp_count !== 16'd0 || bus.kp_x !== 3'd0) begin errors++; $display("FAIL midrst_outputs: kp_count %0d kp_x %0d want 0 0", bus.kp_count, bus.kp_x); end
      @(negedge clk);
      mode = 1; bus.kp_ready = 1'b1; base = qx.size();
      run_frame(1'b0, fe, dn, cyc, to);
      checks++; if (fe !== 55 || dn !== 1) begin errors++; $display("FAIL midrst_rescan: feed %0d done %0d want 55 1", fe, dn); end
      checks++;
      if (qx.size() - base !== 1) begin
         errors++; $display("FAIL midrst_kp_count: got %0d want 1", qx.size() - base);
      end else if (qx[base] !== 3 || qy[base] !== 2 || qv[base] !== 5) begin
         errors++; $display("FAIL midrst_kp: got (%0d,%0d,%0d) want (3,2,5)", qx[base], qy[base], qv[base]);
      end
   endtask

   task automatic test_start_while_busy();
      int fe, dn, cyc; bit to;
      mode = 0; bus.kp_ready = 1'b1;
      run_frame(1'b1, fe, dn, cyc, to);
      checks++; if (fe !== 55) begin errors++; $display("FAIL poke_feed_cycles: got %0d want 55", fe); end
      checks++; if (cyc !== 55 || dn !== 1) begin errors++; $display("FAIL poke_done: cycle %0d pulses %0d want 55 1", cyc, dn); end
      repeat (5) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL poke_rescan: busy %b want 0", bus.busy); end
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.kp_ready   = 1'b1;
      bus.det_flag   = 1'b0;
      bus.det_center = 8'd0;
      test_reset();
      test_empty_frame();
      test_single_kp();
      test_threshold_border();
      test_backpressure();
      test_reset_midframe();
      test_start_while_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/extreme_scan_ctrl.md
Name: extreme_scan_ctrl

Overview:
- Frame-level controller for the 3x3x3 DoG local-extreme detector.
- Paces the detector one pixel per enabled cycle and tracks raster coordinates across the detector's fixed pipeline latency.
- Discards border and low-contrast hits, then queues surviving keypoints (x, y, value) in an internal FIFO with a valid/ready output.
- Sits between the DoG pyramid/line-buffer feed and the downstream keypoint refinement/descriptor stage.

Parameters:
- IMG_W, 640, frame width in pixels.
- IMG_H, 480, frame height in pixels.
- XW, 10, x coordinate width; must satisfy 2^XW >= IMG_W.
- YW, 9, y coordinate width; must satisfy 2^YW >= IMG_H.
- PIPE_LAT, 7, enabled cycles from a pixel's feed_en to its det_flag/det_center being valid.
- THRESH, 3, minimum |center DoG value| for acceptance (unsigned 7-bit).
- FIFO_DEPTH, 8, keypoint FIFO entries; power of two, >= 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame scan; ignored while busy.
- feed_en  out  1  detector/line-buffer advance enable; one pixel consumed per high cycle.
- det_flag  in  1  detector extreme flag for the pixel fed PIPE_LAT enables earlier.
- det_center  in  8  signed centre DoG value aligned with det_flag.
- kp_valid  out  1  keypoint available.
- kp_ready  in  1  downstream accepts keypoint.
- kp_x  out  XW  keypoint centre column.
- kp_y  out  YW  keypoint centre row.
- kp_val  out  8  signed centre DoG value.
- busy  out  1  scan in progress (FEED or DRAIN).
- done  out  1  one-cycle pulse at end of frame.
- kp_count  out  16  keypoints accepted this frame; saturates at 0xFFFF.

Behaviour:
- Reset values: feed_en 0, kp_valid 0, kp_x/kp_y/kp_val 0, busy 0, done 0, kp_count 0, FIFO empty, FSM IDLE.
- States:
  - IDLE: start -> FEED; clear kp_count and the feed x/y and result x/y counters.
  - FEED: feed_en = 1 when FIFO occupancy <= FIFO_DEPTH-2, else 0 (stall). Each enabled cycle advances the feed counter in raster order (x wraps at IMG_W-1 and increments y). After pixel (IMG_W-1, IMG_H-1) is fed -> DRAIN.
  - DRAIN: issue exactly PIPE_LAT further feed_en cycles (dummy pixels), under the same stall rule, then -> DONE.
  - DONE: done = 1 for one cycle, -> IDLE. The FIFO keeps draining in IDLE.
- Alignment:
  - A result counter (rx, ry) advances only on enabled cycles once PIPE_LAT enables have elapsed since start.
  - The detector is frozen while feed_en = 0, so det_flag/det_center are sampled only in cycles where feed_en = 1 and the result counter is live.
- Coordinates: a window whose newest pixel is (rx, ry) has its centre at (rx-1, ry-1). kp_x = rx-1, kp_y = ry-1.
- Border mask: a result is eligible only if rx >= 2 and ry >= 2. This excludes row/column wrap windows; centres span x in 1..IMG_W-2 and y in 1..IMG_H-2.
- Acceptance: push to FIFO iff eligible && det_flag && |det_center| >= THRESH. |-128| is treated as 128.
- kp_count increments on every push.
- FIFO:
  - kp_valid = not empty; outputs show the head entry.
  - A pop occurs when kp_valid && kp_ready.
  - Simultaneous push and pop keeps occupancy unchanged.
  - The stall threshold guarantees no push ever occurs when full (assertion target).
- Push and pop are both single-cycle; an accepted result is visible on kp_valid the cycle after its sampling cycle.
- rst mid-frame: immediate return to IDLE, FIFO flushed, all outputs at reset values. Data already inside the detector pipeline is discarded.
- start during FEED, DRAIN or DONE has no effect.

Test Plan:
- IMG_W=8, IMG_H=6, PIPE_LAT=7, kp_ready=1, det_flag=0 -> feed_en high for exactly 48+7=55 cycles, done pulses once, kp_count=0, kp_valid never 1.
- Same config; det_flag=1, det_center=+5 only on the result sampled at rx=4, ry=3 -> exactly one keypoint, kp_x=3, kp_y=2, kp_val=5, kp_count=1.
- det_flag=1 with det_center=+2, then -3 (THRESH=3) -> first rejected, second accepted with kp_val=-3. det_flag=1 at rx=0 or ry=1 -> rejected (border).
- det_flag=1 on every eligible result, kp_ready=0 -> feed_en drops once occupancy reaches 7, no overflow. Then kp_ready=1 -> 24 keypoints delivered in raster order of centres, kp_count=24.
- Assert rst for one cycle mid-FEED -> next cycle IDLE, kp_valid=0, busy=0. A new start re-scans the full frame with correct coordinates.
- start pulsed while busy -> ignored; the frame completes with the same cycle count as an unperturbed frame.
